memory_port_arbiter: RTL and testbench

- Shares one single-ported, word-addressed memory between the instruction-fetch requester and the load/store data requester.
- Serves a unified program/data memory with one synchronous-read port.
- Arbitrates per cycle, converts byte addresses to word addresses, and rejects misaligned accesses.
- Routes the 1-cycle-latency read data back to whichever requester owns the response.

---
 rtl/memory_port_arbiter.sv | 122 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_port_arbiter
//  Description : Shares one synchronous-read, word-addressed memory port
//                between an instruction-fetch requester and a load/store
//                requester. Per-cycle arbitration with a bounded data streak,
//                byte-to-word address conversion, misalignment rejection and
//                one-cycle read-response routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    // Instruction fetch requester
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    // Load/store requester
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    // Memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] C_MAX_STREAK = 4'(MAX_DATA_STREAK);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF_RD  = 3'd1,
        S_D_RD   = 3'd2,
        S_IF_ERR = 3'd3,
        S_D_ERR  = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_streak;

    logic       w_fetch_wins;
    logic       w_if_aligned;
    logic       w_d_aligned;

    // Fetch wins when it is alone, or when data has used up its streak allowance
    assign w_fetch_wins = if_req && (!d_req || (r_streak == C_MAX_STREAK));
    assign if_gnt       = !reset && w_fetch_wins;
    assign d_gnt        = !reset && d_req && !w_fetch_wins;

    assign w_if_aligned = (if_addr[1:0] == 2'b00);
    assign w_d_aligned  = (d_addr[1:0] == 2'b00);

    // Drive the memory port from the granted requester; misaligned grants never touch memory
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt && w_if_aligned) begin
            mem_en   = 1'b1;
            mem_addr = {2'b00, if_addr[ADDR_WIDTH-1:2]};
        end else if (d_gnt && w_d_aligned) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = {2'b00, d_addr[ADDR_WIDTH-1:2]};
            mem_wdata = d_wdata;
        end
    end

    // Response state and data-streak counter; the state records who owns next cycle's read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_streak <= 4'd0;
        end else begin
            if (if_gnt) begin
                r_state <= w_if_aligned ? S_IF_RD : S_IF_ERR;
            end else if (d_gnt) begin
                if (!w_d_aligned) begin
                    r_state <= S_D_ERR;
                end else if (d_we) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_D_RD;
                end
            end else begin
                r_state <= S_IDLE;
            end

            if (if_gnt || !if_req) begin
                r_streak <= 4'd0;
            end else if (d_gnt && (r_streak != C_MAX_STREAK)) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

    // Response outputs decode the registered state; reset suppresses an in-flight response at once
    assign if_rvalid = !reset && ((r_state == S_IF_RD) || (r_state == S_IF_ERR));
    assign if_err    = !reset && (r_state == S_IF_ERR);
    assign if_rdata  = (!reset && (r_state == S_IF_RD)) ? mem_rdata : '0;

    assign d_rvalid  = !reset && ((r_state == S_D_RD) || (r_state == S_D_ERR));
    assign d_err     = !reset && (r_state == S_D_ERR);
    assign d_rdata   = (!reset && (r_state == S_D_RD)) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_port_arbiter
//  Description : Directed self-checking bench for memory_port_arbiter with a
//                behavioural synchronous-read memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:63];

    memory_port_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MAX_DATA_STREAK(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs just after the falling edge, then settle before checking
    task automatic drive(input logic rst, input logic ireq, input logic [AW-1:0] ia,
                         input logic dreq, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        @(negedge clk);
        reset   = rst;
        if_req  = ireq;
        if_addr = ia;
        d_req   = dreq;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = wd;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    logic exp_if_pat [0:7];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem_rdata = '0;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        exp_if_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held with both requests pending
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h20, '0);
            chk("rst_if_gnt", 64'(if_gnt), 64'd0);
            chk("rst_d_gnt", 64'(d_gnt), 64'd0);
            chk("rst_mem_en", 64'(mem_en), 64'd0);
            chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
            chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        end

        // First cycle after release: data wins, no response yet
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h20, '0);
        chk("post_rst_d_gnt", 64'(d_gnt), 64'd1);
        chk("post_rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("post_rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        chk("post_rst_mem_addr", 64'(mem_addr), 64'd8);
        idle();
        chk("load8_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("load8_d_rdata", 64'(d_rdata), 64'hA000_0008);
        chk("idle_mem_en", 64'(mem_en), 64'd0);
        chk("idle_mem_addr", 64'(mem_addr), 64'd0);

        // Fetch-only stream
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        chk("f0_if_gnt", 64'(if_gnt), 64'd1);
        chk("f0_mem_addr", 64'(mem_addr), 64'd0);
        chk("f0_d_rvalid", 64'(d_rvalid), 64'd0);
        drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
        chk("f1_mem_addr", 64'(mem_addr), 64'd1);
        chk("f1_mem_we", 64'(mem_we), 64'd0);
        chk("f1_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("f1_if_rdata", 64'(if_rdata), 64'hA000_0000);
        drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
        chk("f2_mem_addr", 64'(mem_addr), 64'd2);
        chk("f2_if_rdata", 64'(if_rdata), 64'hA000_0001);
        idle();
        chk("f3_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("f3_if_rdata", 64'(if_rdata), 64'hA000_0002);
        chk("f3_if_err", 64'(if_err), 64'd0);
        idle();
        chk("f4_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("f4_if_rdata", 64'(if_rdata), 64'd0);

        // Store then load back
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        chk("st_d_gnt", 64'(d_gnt), 64'd1);
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_addr", 64'(mem_addr), 64'd4);
        chk("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h10, '0);
        chk("st_no_rvalid", 64'(d_rvalid), 64'd0);
        chk("ld_mem_en", 64'(mem_en), 64'd1);
        chk("ld_mem_we", 64'(mem_we), 64'd0);
        idle();
        chk("ld_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("ld_d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
        chk("ld_d_err", 64'(d_err), 64'd0);

        // Contention: D,D,D,IF,D,D,D,IF
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, '0);
            chk($sformatf("cont%0d_if_gnt", i), 64'(if_gnt), 64'(exp_if_pat[i]));
            chk($sformatf("cont%0d_d_gnt", i), 64'(d_gnt), 64'(!exp_if_pat[i]));
        end
        idle();
        idle();

        // Misaligned load, then misaligned fetch
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h6, '0);
        chk("mis_ld_d_gnt", 64'(d_gnt), 64'd1);
        chk("mis_ld_mem_en", 64'(mem_en), 64'd0);
        drive(1'b0, 1'b1, 32'h2, 1'b0, 1'b0, '0, '0);
        chk("mis_ld_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("mis_ld_d_err", 64'(d_err), 64'd1);
        chk("mis_ld_d_rdata", 64'(d_rdata), 64'd0);
        chk("mis_if_gnt", 64'(if_gnt), 64'd1);
        chk("mis_if_mem_en", 64'(mem_en), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h3, 32'h1234_5678);
        chk("mis_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("mis_if_err", 64'(if_err), 64'd1);
        chk("mis_if_rdata", 64'(if_rdata), 64'd0);
        chk("mis_st_mem_we", 64'(mem_we), 64'd0);
        chk("mis_st_mem_en", 64'(mem_en), 64'd0);
        idle();
        chk("mis_st_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("mis_st_d_err", 64'(d_err), 64'd1);

        // Reset in the cycle a fetch response is due
        drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
        chk("rmid_if_gnt", 64'(if_gnt), 64'd1);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("rmid_if_rvalid_n1", 64'(if_rvalid), 64'd0);
        chk("rmid_if_rdata_n1", 64'(if_rdata), 64'd0);
        idle();
        chk("rmid_if_rvalid_n2", 64'(if_rvalid), 64'd0);
        chk("rmid_d_rvalid_n2", 64'(d_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
